// File: rtl/act_double_buffer_if.sv
// Write-port and read-port signals of the ping-pong activation buffer.
// The master side is the producer/consumer pair; the slave side is the buffer.
interface act_double_buffer_if #(
    parameter int WORD_W = 256,
    parameter int REP_W  = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] wr_data;
    logic              wr_last;
    logic [REP_W-1:0]  cfg_passes;

    logic              rd_en;
    logic [WORD_W-1:0] act_db_out;
    logic              out_valid;
    logic              out_first;
    logic              out_last;

    modport master (
        output wr_valid, wr_data, wr_last, cfg_passes, rd_en,
        input  wr_ready, act_db_out, out_valid, out_first, out_last
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, cfg_passes, rd_en,
        output wr_ready, act_db_out, out_valid, out_first, out_last
    );
endinterface

// File: rtl/act_double_buffer.sv
// Ping-pong activation buffer: one bank fills from the write port while the other
// streams to the cores, replaying each stored vector a configurable number of passes.
module act_double_buffer #(
    parameter int WORD_W = 256,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int REP_W  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    act_double_buffer_if.slave   db,
    output logic [1:0]           banks_full
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_state_e;

    bank_state_e       state_q    [2];
    bank_state_e       state_d    [2];
    logic [ADDR_W-1:0] last_idx_q [2];
    logic [ADDR_W-1:0] last_idx_d [2];
    logic [REP_W-1:0]  passes_q   [2];
    logic [REP_W-1:0]  passes_d   [2];

    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [REP_W-1:0]  pass_idx_q, pass_idx_d;

    logic [WORD_W-1:0] act_out_q, act_out_d;
    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;
    logic [1:0]        banks_full_q, banks_full_d;

    logic [WORD_W-1:0] mem_q [2][DEPTH];

    logic wr_ready;
    logic rd_avail;
    logic wr_fire;
    logic wr_close;
    logic rd_fire;
    logic rd_word_last;
    logic rd_final_pass;

    assign wr_ready      = (state_q[wr_bank_q] == BANK_EMPTY) || (state_q[wr_bank_q] == BANK_FILLING);
    assign rd_avail      = (state_q[rd_bank_q] == BANK_FULL)  || (state_q[rd_bank_q] == BANK_READING);
    assign wr_fire       = db.wr_valid && wr_ready && !flush;
    assign wr_close      = wr_fire && (db.wr_last || (wr_ptr_q == ADDR_W'(DEPTH - 1)));
    assign rd_fire       = db.rd_en && rd_avail && !flush;
    assign rd_word_last  = (rd_ptr_q == last_idx_q[rd_bank_q]);
    // pass_idx counts completed passes upward, so no reload from the next bank is needed
    assign rd_final_pass = (pass_idx_q == (passes_q[rd_bank_q] - REP_W'(1)));

    always_comb begin
        state_d      = state_q;
        last_idx_d   = last_idx_q;
        passes_d     = passes_q;
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = wr_ptr_q;
        rd_bank_d    = rd_bank_q;
        rd_ptr_d     = rd_ptr_q;
        pass_idx_d   = pass_idx_q;
        act_out_d    = act_out_q;
        out_valid_d  = 1'b0;
        out_first_d  = 1'b0;
        out_last_d   = 1'b0;
        banks_full_d = 2'd0;

        if (flush) begin
            state_d[0] = BANK_EMPTY;
            state_d[1] = BANK_EMPTY;
            wr_bank_d  = 1'b0;
            wr_ptr_d   = '0;
            rd_bank_d  = 1'b0;
            rd_ptr_d   = '0;
            pass_idx_d = '0;
            act_out_d  = '0;
        end else begin
            if (wr_fire) begin
                state_d[wr_bank_q] = BANK_FILLING;
                wr_ptr_d           = wr_ptr_q + ADDR_W'(1);
                if (wr_close) begin
                    state_d[wr_bank_q]    = BANK_FULL;
                    last_idx_d[wr_bank_q] = wr_ptr_q;
                    passes_d[wr_bank_q]   = (db.cfg_passes == '0) ? REP_W'(1) : db.cfg_passes;
                    wr_ptr_d              = '0;
                    wr_bank_d             = ~wr_bank_q;
                end
            end

            // The write bank and the read bank can never coincide while both fire
            if (rd_fire) begin
                state_d[rd_bank_q] = BANK_READING;
                act_out_d          = mem_q[rd_bank_q][rd_ptr_q];
                out_valid_d        = 1'b1;
                out_first_d        = (rd_ptr_q == '0);
                out_last_d         = rd_word_last && rd_final_pass;
                if (rd_word_last) begin
                    rd_ptr_d = '0;
                    if (rd_final_pass) begin
                        state_d[rd_bank_q] = BANK_EMPTY;
                        rd_bank_d          = ~rd_bank_q;
                        pass_idx_d         = '0;
                    end else begin
                        pass_idx_d = pass_idx_q + REP_W'(1);
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                end
            end
        end

        for (int b = 0; b < 2; b++) begin
            if ((state_d[b] == BANK_FULL) || (state_d[b] == BANK_READING)) begin
                banks_full_d = banks_full_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b]    <= BANK_EMPTY;
                last_idx_q[b] <= '0;
                passes_q[b]   <= REP_W'(1);
            end
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_bank_q    <= 1'b0;
            rd_ptr_q     <= '0;
            pass_idx_q   <= '0;
            act_out_q    <= '0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            banks_full_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            last_idx_q   <= last_idx_d;
            passes_q     <= passes_d;
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_bank_q    <= rd_bank_d;
            rd_ptr_q     <= rd_ptr_d;
            pass_idx_q   <= pass_idx_d;
            act_out_q    <= act_out_d;
            out_valid_q  <= out_valid_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            banks_full_q <= banks_full_d;
        end
    end

    // Bank storage carries no reset; bank state alone decides what is valid
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_ptr_q] <= db.wr_data;
        end
    end

    assign db.wr_ready   = wr_ready;
    assign db.act_db_out = act_out_q;
    assign db.out_valid  = out_valid_q;
    assign db.out_first  = out_first_q;
    assign db.out_last   = out_last_q;
    assign banks_full    = banks_full_q;

endmodule

// File: tb/tb_act_double_buffer.sv
// Scoreboard bench for act_double_buffer: each closed vector expands into its expected
// replayed word stream; a monitor compares every presented word and the bank occupancy.
module tb_act_double_buffer;
    localparam int WORD_W = 256;
    localparam int DEPTH  = 16;
    localparam int REP_W  = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] banks_full;

    act_double_buffer_if #(.WORD_W(WORD_W), .REP_W(REP_W)) db ();

    act_double_buffer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .db         (db),
        .banks_full (banks_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] data;
        logic              first;
        logic              last;
    } exp_t;

    typedef struct {
        logic [WORD_W-1:0] data;
        logic              last;
        logic [REP_W-1:0]  passes;
    } word_t;

    exp_t              exp_q[$];
    word_t             pend_q[$];
    logic [WORD_W-1:0] cur_vec[$];
    int                held = 0;
    int                vectors = 0;
    int                miscompares = 0;
    logic [WORD_W-1:0] last_data = '0;

    function automatic logic [WORD_W-1:0] randWord();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic queueVector(input int len, input int passes, input bit use_last);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data   = randWord();
            w.last   = use_last && (i == len - 1);
            w.passes = REP_W'(passes);
            pend_q.push_back(w);
        end
    endtask

    // A closed vector becomes passes x len expected words, first on each pass start
    function automatic void modelWrite(input word_t w);
        int   p;
        exp_t e;
        cur_vec.push_back(w.data);
        if (w.last || cur_vec.size() == DEPTH) begin
            p = (w.passes == 0) ? 1 : int'(w.passes);
            for (int pass = 0; pass < p; pass++) begin
                for (int i = 0; i < cur_vec.size(); i++) begin
                    e.data  = cur_vec[i];
                    e.first = (i == 0);
                    e.last  = (pass == p - 1) && (i == cur_vec.size() - 1);
                    exp_q.push_back(e);
                end
            end
            held++;
            cur_vec.delete();
        end
    endfunction

    function automatic void clearModel();
        exp_q.delete();
        pend_q.delete();
        cur_vec.delete();
        held = 0;
    endfunction

    task automatic applyStimulus(input int cycles, input int rd_pct, input int wr_pct);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            db.rd_en = ($urandom_range(99) < rd_pct);
            if (pend_q.size() > 0 && $urandom_range(99) < wr_pct) begin
                db.wr_valid   = 1'b1;
                db.wr_data    = pend_q[0].data;
                db.wr_last    = pend_q[0].last;
                db.cfg_passes = pend_q[0].passes;
                if (db.wr_ready) modelWrite(pend_q.pop_front());
            end else begin
                db.wr_valid   = 1'b0;
                db.wr_data    = randWord();
                db.wr_last    = $urandom_range(1);
                db.cfg_passes = REP_W'($urandom_range(15));
            end
        end
    endtask

    task automatic drain();
        int budget = 3000;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && budget > 0) begin
            applyStimulus(1, 100, 100);
            budget--;
        end
        applyStimulus(2, 0, 0);
        checkOutput("drain_left", WORD_W'(exp_q.size() + pend_q.size() + cur_vec.size()), '0);
    endtask

    task automatic doFlush();
        @(negedge clk);
        flush       = 1'b1;
        db.wr_valid = 1'b1;
        db.wr_data  = randWord();
        db.wr_last  = 1'b1;
        db.rd_en    = 1'b1;
        clearModel();
        @(negedge clk);
        flush       = 1'b0;
        db.wr_valid = 1'b0;
        db.rd_en    = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstn        = 1'b0;
        db.wr_valid = 1'b0;
        db.rd_en    = 1'b1;
        clearModel();
        @(negedge clk);
        rstn        = 1'b1;
        db.rd_en    = 1'b0;
    endtask

    // Monitor: a read fires only when some bank was held before the edge
    initial begin
        int   prev_held;
        logic exp_valid;
        exp_t e;
        prev_held = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rstn || flush) begin
                checkOutput("clr_out_valid", WORD_W'(db.out_valid), '0);
                checkOutput("clr_out_first", WORD_W'(db.out_first), '0);
                checkOutput("clr_out_last", WORD_W'(db.out_last), '0);
                checkOutput("clr_act_db_out", db.act_db_out, '0);
                checkOutput("clr_banks_full", WORD_W'(banks_full), '0);
                checkOutput("clr_wr_ready", WORD_W'(db.wr_ready), WORD_W'(1));
                last_data = '0;
                prev_held = 0;
            end else begin
                exp_valid = db.rd_en && (prev_held > 0);
                checkOutput("out_valid", WORD_W'(db.out_valid), WORD_W'(exp_valid));
                if (db.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_word", WORD_W'(1), '0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("act_db_out", db.act_db_out, e.data);
                        checkOutput("out_first", WORD_W'(db.out_first), WORD_W'(e.first));
                        checkOutput("out_last", WORD_W'(db.out_last), WORD_W'(e.last));
                        if (e.last) held--;
                        last_data = e.data;
                    end
                end else begin
                    checkOutput("hold_act_db_out", db.act_db_out, last_data);
                    checkOutput("idle_flags", WORD_W'({db.out_first, db.out_last}), '0);
                end
                checkOutput("banks_full", WORD_W'(banks_full), WORD_W'(held));
                checkOutput("wr_ready", WORD_W'(db.wr_ready), WORD_W'(held < 2));
                prev_held = held;
            end
        end
    end

    initial begin
        int len;
        db.wr_valid   = 1'b0;
        db.wr_data    = '0;
        db.wr_last    = 1'b0;
        db.cfg_passes = '0;
        db.rd_en      = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        $display("[TB] single pass vector, len 4");
        queueVector(4, 1, 1);
        applyStimulus(12, 100, 100);
        drain();

        $display("[TB] len 1 vectors, passes 1 and 0");
        queueVector(1, 1, 1);
        queueVector(1, 0, 1);
        applyStimulus(8, 100, 100);
        drain();

        $display("[TB] len 2 replayed 3 passes");
        queueVector(2, 3, 1);
        applyStimulus(12, 100, 100);
        drain();

        $display("[TB] three vectors back to back, reader stalled");
        queueVector(3, 1, 1);
        queueVector(3, 2, 1);
        queueVector(3, 1, 1);
        applyStimulus(15, 0, 100);
        applyStimulus(30, 100, 100);
        drain();

        $display("[TB] auto-close at full depth");
        queueVector(DEPTH, 1, 0);
        queueVector(3, 2, 1);
        applyStimulus(60, 100, 100);
        drain();

        $display("[TB] alternating rd_en");
        queueVector(8, 2, 1);
        for (int i = 0; i < 40; i++) applyStimulus(1, (i % 2 == 0) ? 100 : 0, 100);
        drain();

        $display("[TB] flush mid-read with both banks full");
        queueVector(4, 2, 1);
        queueVector(4, 2, 1);
        applyStimulus(12, 0, 100);
        applyStimulus(3, 100, 0);
        doFlush();
        queueVector(3, 1, 1);
        applyStimulus(15, 100, 100);
        drain();

        $display("[TB] reset mid-read with both banks full");
        queueVector(5, 2, 1);
        queueVector(2, 3, 1);
        applyStimulus(12, 0, 100);
        applyStimulus(4, 100, 0);
        doReset();
        queueVector(3, 2, 1);
        applyStimulus(15, 100, 100);
        drain();

        $display("[TB] randomized traffic");
        for (int v = 0; v < 14; v++) begin
            len = $urandom_range(DEPTH, 1);
            queueVector(len, $urandom_range(5), (len < DEPTH) ? 1'b1 : 1'($urandom_range(1)));
        end
        applyStimulus(400, 70, 70);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/act_double_buffer.md
Name: act_double_buffer

Overview:
Ping-pong activation buffer that sits directly upstream of the core array and drives each core's act_db_in bus. One bank fills from the activation write port (row-buffer/NoC side) while the other bank streams to the cores. Each stored vector can be replayed a configurable number of passes so one activation set serves several weight tiles. Banks swap when the fill bank is complete and the read bank has been released.

Parameters:
WORD_W, 256, activation wordline width; equals ACT_DB_WORDLINE.
DEPTH, 16, words per bank; power of 2, at least 2.
ADDR_W, $clog2(DEPTH), bank word address width.
REP_W, 4, width of the replay-pass count.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of both banks and all pointers
wr_valid  in  1  write word valid
wr_ready  out  1  write bank can accept a word
wr_data  in  WORD_W  activation word
wr_last  in  1  last word of the vector; closes the bank
cfg_passes  in  REP_W  read passes for the bank being closed; 0 is treated as 1
rd_en  in  1  consumer requests the next word
act_db_out  out  WORD_W  registered activation word to the cores
out_valid  out  1  act_db_out holds a new word this cycle
out_first  out  1  first word of a pass
out_last  out  1  last word of the final pass of a bank
banks_full  out  2  number of banks in FULL or READING state

Behaviour:
- Storage: 2 x DEPTH x WORD_W flops or RAM. Each bank has a state (EMPTY, FILLING, FULL, READING), a len (1..DEPTH) and passes (1..2^REP_W-1).
- Reset or flush: both banks EMPTY; wr_bank=0, rd_bank=0, pointers 0.
  - Output reset values: act_db_out=0, out_valid=0, out_first=0, out_last=0, banks_full=0, wr_ready=1.
  - flush wins over any simultaneous write or read.
- Write side:
  - wr_ready = (state[wr_bank] is EMPTY or FILLING). It is computed from registered state only.
  - On a wr_valid & wr_ready fire: word goes to wr_bank at wr_ptr; the bank becomes FILLING.
  - A bank closes when wr_last is set or wr_ptr==DEPTH-1. On close: state goes to FULL, len=wr_ptr+1, passes=max(cfg_passes,1) sampled that cycle, wr_ptr=0, wr_bank toggles.
  - A second vector can be written back-to-back into the other bank if it is EMPTY. Otherwise wr_ready=0 until that bank is released.
- Read side (single rd_bank pointer and rd_ptr, pass counter):
  - A read fires when rd_en=1 and state[rd_bank] is FULL or READING. On the first fire a FULL bank becomes READING.
  - Latency is 1 cycle. The cycle after a fire: act_db_out=mem[rd_bank][rd_ptr] and out_valid=1.
    - out_first=1 when rd_ptr was 0.
    - out_last=1 when rd_ptr==len-1 and this is the final pass.
  - No fire (rd_en=0 or bank not ready): out_valid, out_first and out_last are 0 next cycle; act_db_out holds its value.
  - At rd_ptr==len-1: rd_ptr goes to 0.
    - If passes remain, the pass counter decrements and the same bank repeats.
    - On the final pass the bank becomes EMPTY, rd_bank toggles, and the pass counter reloads from the next bank.
  - A release is visible to wr_ready on the next cycle, never combinationally.
  - A bank filling and being read at the same time is impossible: a bank is only read once FULL.
- Same-cycle events:
  - Write close on bank A plus read release of bank B: both update. Reading continues on A next cycle with no bubble if rd_en stays 1.
  - Bank closes in the same cycle the reader waits on it: the reader starts the next cycle.
- banks_full counts FULL and READING banks; range 0..2.
- Boundaries:
  - len=1 with passes=1: out_first and out_last both assert on the same word.
  - A write of DEPTH words without wr_last auto-closes the bank.
  - rstn asserted mid-stream aborts everything immediately. Stale bank data need not be cleared, but state must read EMPTY.

Test Plan:
1. Fill bank0 with 4 words (A0..A3, wr_last on A3), cfg_passes=1, rd_en=1 held -> out_valid on 4 consecutive cycles starting 1 cycle after first fire, data A0..A3, out_first on A0, out_last on A3, banks_full 1->0.
2. cfg_passes=3, len=2 (B0,B1) -> output sequence B0,B1,B0,B1,B0,B1; out_first on each B0; out_last only on the 6th word; bank EMPTY afterwards.
3. Write 3 vectors back-to-back with rd_en=0 -> wr_ready drops after 2nd close, banks_full=2. Raise rd_en -> after 1st bank drains, wr_ready rises exactly 1 cycle after release; 3rd vector accepted.
4. Write DEPTH=16 words with no wr_last -> bank auto-closes with len=16; the 17th word goes to bank1.
5. Toggle rd_en 1,0,1,0 mid-stream -> out_valid follows with 1-cycle delay, act_db_out holds during gaps, no word skipped or duplicated.
6. Assert flush (and separately rstn) mid-read with banks_full=2 -> next cycle out_valid=0, banks_full=0, wr_ready=1; new vector after flush reads back correctly starting from bank0.
